// File: rtl/svc_rv_cpi_pkg.sv
// Shared types for the CPI monitor: the controller state encoding.
package svc_rv_cpi_pkg;

  typedef enum logic [1:0] {
    COUNT  = 2'd0,
    DIV    = 2'd1,
    DONE   = 2'd2,
    HALTED = 2'd3
  } cpi_state_t;

endpackage

// File: rtl/svc_divu_iter.sv
// Iterative restoring unsigned divider: one quotient bit per clock, MSB first.
// A zero divisor skips the iterations and finishes on the next edge with an
// all-ones quotient. 'done' is high during the edge that completes the
// divide, and 'quotient' then carries the final value so the caller can
// capture it on that same edge.
module svc_divu_iter #(
  parameter int WIDTH = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             r_busy;
  logic             r_dz;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_bit;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  // One restoring step: shift in the next dividend bit, trial-subtract.
  always_comb begin
    w_shift   = {r_rem, r_quo[WIDTH-1]};
    w_diff    = w_shift - {1'b0, r_div};
    w_bit     = ~w_diff[WIDTH];
    w_rem_nxt = w_bit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    w_quo_nxt = r_dz ? '1 : {r_quo[WIDTH-2:0], w_bit};
  end

  assign busy     = r_busy;
  assign done     = r_busy && (r_dz || (r_cnt == CW'(1)));
  assign quotient = w_quo_nxt;
  assign div_zero = r_dz;

  // Load on start, iterate while busy; abort drops any divide in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_dz   <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
    end else if (abort) begin
      r_busy <= 1'b0;
      r_dz   <= 1'b0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_dz   <= (divisor == '0);
      r_cnt  <= CW'(WIDTH);
      r_rem  <= '0;
      r_quo  <= dividend;
      r_div  <= divisor;
    end else if (r_busy) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt - CW'(1);
      if (done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/svc_rv_cpi_monitor.sv
// CPI monitor: counts cycles and retired instructions until the core halts,
// then divides (cycles << FRAC_W) / instrs and offers the result on a
// valid/ready port.
// Handshake: cpi_valid stays high with cpi/div_zero stable until the edge
// where cpi_valid && cpi_ready; it then drops and cpi keeps its value.
module svc_rv_cpi_monitor
  import svc_rv_cpi_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int FRAC_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    retire,
  input  logic                    halt,
  output logic [CNT_W-1:0]        cycles,
  output logic [CNT_W-1:0]        instrs,
  output logic                    cpi_valid,
  input  logic                    cpi_ready,
  output logic [CNT_W+FRAC_W-1:0] cpi,
  output logic                    div_zero,
  output cpi_state_t              dbg_state
);

  localparam int Q = CNT_W + FRAC_W;

  cpi_state_t       r_state;
  cpi_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cycles;
  logic [CNT_W-1:0] r_instrs;
  logic [Q-1:0]     r_cpi;
  logic             r_div_zero;

  logic             w_start;
  logic             w_count;
  logic             w_div_busy;
  logic             w_div_done_raw;
  logic             w_div_done;
  logic [Q-1:0]     w_quotient;
  logic             w_dz;

  svc_divu_iter #(.WIDTH(Q)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_start),
    .abort    (clear),
    .dividend ({r_cycles, {FRAC_W{1'b0}}}),
    .divisor  ({{FRAC_W{1'b0}}, r_instrs}),
    .busy     (w_div_busy),
    .done     (w_div_done_raw),
    .quotient (w_quotient),
    .div_zero (w_dz)
  );

  assign w_div_done = w_div_busy && w_div_done_raw;

  // Next-state and control strobes; clear overrides everything else.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_count     = 1'b0;
    case (r_state)
      COUNT: begin
        if (halt) begin
          w_state_nxt = DIV;
          w_start     = 1'b1;
        end else begin
          w_count = 1'b1;
        end
      end
      DIV:     if (w_div_done) w_state_nxt = DONE;
      DONE:    if (cpi_ready) w_state_nxt = HALTED;
      HALTED:  w_state_nxt = HALTED;
      default: w_state_nxt = COUNT;
    endcase
    if (clear) begin
      w_state_nxt = COUNT;
      w_start     = 1'b0;
      w_count     = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= COUNT;
    else        r_state <= w_state_nxt;
  end

  // Saturating cycle/instruction counters, live only while counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycles <= '0;
      r_instrs <= '0;
    end else if (clear) begin
      r_cycles <= '0;
      r_instrs <= '0;
    end else if (w_count) begin
      if (r_cycles != '1) r_cycles <= r_cycles + CNT_W'(1);
      if (retire && (r_instrs != '1)) r_instrs <= r_instrs + CNT_W'(1);
    end
  end

  // Capture the divider result on the edge that completes the divide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpi      <= '0;
      r_div_zero <= 1'b0;
    end else if (clear) begin
      r_div_zero <= 1'b0;
    end else if ((r_state == DIV) && w_div_done) begin
      r_cpi      <= w_quotient;
      r_div_zero <= w_dz;
    end
  end

  assign cycles    = r_cycles;
  assign instrs    = r_instrs;
  assign cpi       = r_cpi;
  assign div_zero  = r_div_zero;
  assign cpi_valid = (r_state == DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_svc_rv_cpi_monitor.sv
// Bench for the CPI monitor: directed table of runs, hand-written corner
// sequences (clear mid-divide, clear with halt, async reset, saturation on a
// narrow instance) and randomized runs scored against a plain-arithmetic model.
module tb_svc_rv_cpi_monitor;
  import svc_rv_cpi_pkg::*;

  localparam logic [39:0] ALL1 = 40'hFF_FFFF_FFFF;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance (32.8)
  logic        clear = 0, retire = 0, halt = 0, cpi_ready = 0;
  logic [31:0] cycles, instrs;
  logic        cpi_valid, div_zero;
  logic [39:0] cpi;
  cpi_state_t  dbg_state;

  svc_rv_cpi_monitor #(.CNT_W(32), .FRAC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .retire(retire), .halt(halt),
    .cycles(cycles), .instrs(instrs), .cpi_valid(cpi_valid),
    .cpi_ready(cpi_ready), .cpi(cpi), .div_zero(div_zero),
    .dbg_state(dbg_state)
  );

  // Narrow instance (8.8) used to reach counter saturation quickly
  logic        s_clear = 0, s_retire = 0, s_halt = 0, s_ready = 0;
  logic [7:0]  s_cycles, s_instrs;
  logic        s_valid, s_dz;
  logic [15:0] s_cpi;
  cpi_state_t  s_state;

  svc_rv_cpi_monitor #(.CNT_W(8), .FRAC_W(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .clear(s_clear), .retire(s_retire),
    .halt(s_halt), .cycles(s_cycles), .instrs(s_instrs), .cpi_valid(s_valid),
    .cpi_ready(s_ready), .cpi(s_cpi), .div_zero(s_dz), .dbg_state(s_state)
  );

  // Scoreboard
  int checks = 0;
  int failures = 0;
  logic [39:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: CPI from the counts with plain integer arithmetic.
  function automatic logic [39:0] model_cpi(input longint unsigned cyc, input longint unsigned ins);
    if (ins == 0) return ALL1;
    return 40'((cyc * 256) / ins);
  endfunction

  // Driver tasks
  task automatic start_run;
    clear = 1'b1; halt = 1'b0; retire = 1'b0; cpi_ready = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  // period>0: retire on every period-th cycle, first nret of them;
  // period==0: random retire with probability thresh/4.
  task automatic drive_count(input int ncyc, input int period, input int nret,
                             input int thresh, output int got_ret);
    got_ret = 0;
    for (int i = 0; i < ncyc; i++) begin
      halt = 1'b0;
      if (period > 0) retire = ((i % period) == 0) && ((i / period) < nret);
      else            retire = ($urandom_range(0, 3) < thresh);
      if (retire) got_ret++;
      tick();
    end
    retire = 1'b0;
  endtask

  // Halt, wait for the result, check it, hold, accept, then check the freeze.
  task automatic halt_and_check(input string tag, input logic [31:0] ecyc,
                                input logic [31:0] eins, input logic [39:0] ecpi,
                                input logic edz, input int elat, input int hold);
    int lat;
    halt = 1'b1;
    retire = 1'b1;
    tick();
    chk({tag, ".frz_cyc"}, cycles, ecyc);
    chk({tag, ".frz_ins"}, instrs, eins);
    chk({tag, ".st_div"}, 64'(dbg_state), 64'(DIV));
    lat = 0;
    while (!cpi_valid && lat < 100) begin
      halt = 1'($urandom_range(0, 1));
      retire = 1'($urandom_range(0, 1));
      tick();
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(elat));
    chk({tag, ".cpi"}, cpi, ecpi);
    chk({tag, ".dz"}, div_zero, edz);
    for (int h = 0; h < hold; h++) begin
      halt = 1'($urandom_range(0, 1));
      retire = 1'($urandom_range(0, 1));
      tick();
      chk({tag, ".hold_valid"}, cpi_valid, 1'b1);
      chk({tag, ".hold_cpi"}, cpi, ecpi);
    end
    cpi_ready = 1'b1;
    tick();
    cpi_ready = 1'b0;
    chk({tag, ".valid_drop"}, cpi_valid, 1'b0);
    chk({tag, ".cpi_kept"}, cpi, ecpi);
    for (int h = 0; h < 6; h++) begin
      halt = 1'($urandom_range(0, 1));
      retire = 1'($urandom_range(0, 1));
      tick();
    end
    chk({tag, ".halted_cyc"}, cycles, ecyc);
    chk({tag, ".halted_ins"}, instrs, eins);
    chk({tag, ".halted_valid"}, cpi_valid, 1'b0);
    halt = 1'b0;
    retire = 1'b0;
  endtask

  // Directed vector table
  typedef struct {
    int          ncyc;
    int          period;
    int          nret;
    logic [31:0] ecyc;
    logic [31:0] eins;
    logic [39:0] ecpi;
    logic        edz;
    int          elat;
    int          hold;
  } vec_t;

  vec_t vecs[4];

  // Watchdog
  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int got;
    int lat;
    logic seen;
    logic [39:0] e;

    vecs[0] = '{100, 2, 50, 32'd100, 32'd50, 40'h200, 1'b0, 40, 5};
    vecs[1] = '{3,   1, 2,  32'd3,   32'd2,  40'h180, 1'b0, 40, 0};
    vecs[2] = '{10,  3, 3,  32'd10,  32'd3,  40'h355, 1'b0, 40, 2};
    vecs[3] = '{7,   1, 0,  32'd7,   32'd0,  ALL1,    1'b1, 1,  3};

    // Reset values
    #12;
    chk("rst.cycles", cycles, 32'd0);
    chk("rst.instrs", instrs, 32'd0);
    chk("rst.cpi", cpi, 40'd0);
    chk("rst.valid", cpi_valid, 1'b0);
    chk("rst.dz", div_zero, 1'b0);
    #10 rst_n = 1'b1;
    tick();

    // Directed table
    foreach (vecs[k]) begin
      start_run();
      drive_count(vecs[k].ncyc, vecs[k].period, vecs[k].nret, 0, got);
      halt_and_check($sformatf("vec%0d", k), vecs[k].ecyc, vecs[k].eins,
                     vecs[k].ecpi, vecs[k].edz, vecs[k].elat, vecs[k].hold);
    end

    // Clear 10 cycles into the divide: result never appears, counting restarts
    start_run();
    drive_count(20, 2, 10, 0, got);
    halt = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("clr.in_div", 64'(dbg_state), 64'(DIV));
    clear = 1'b1;
    halt = 1'b0;
    tick();
    clear = 1'b0;
    chk("clr.cycles0", cycles, 32'd0);
    chk("clr.instrs0", instrs, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 45; i++) begin
      retire = ((i % 3) == 0);
      tick();
      if (cpi_valid) seen = 1'b1;
      if (i == 0) chk("clr.cycles1", cycles, 32'd1);
    end
    retire = 1'b0;
    chk("clr.no_valid", seen, 1'b0);
    halt_and_check("clr.rerun", 32'd45, 32'd15, 40'h300, 1'b0, 40, 1);

    // clear and halt together: clear wins, halt is taken next cycle
    start_run();
    drive_count(5, 1, 5, 0, got);
    clear = 1'b1;
    halt = 1'b1;
    tick();
    clear = 1'b0;
    chk("clrhalt.cycles", cycles, 32'd0);
    chk("clrhalt.state", 64'(dbg_state), 64'(COUNT));
    halt_and_check("clrhalt", 32'd0, 32'd0, ALL1, 1'b1, 1, 0);

    // Randomized runs against the model
    for (int r = 0; r < 8; r++) begin
      int ncyc;
      int thr;
      ncyc = $urandom_range(1, 150);
      thr = (r == 3) ? 0 : $urandom_range(1, 4);
      start_run();
      drive_count(ncyc, 0, 0, thr, got);
      exp_q.push_back(model_cpi(longint'(ncyc), longint'(got)));
      e = exp_q.pop_front();
      halt_and_check($sformatf("rnd%0d", r), 32'(ncyc), 32'(got), e,
                     (got == 0), (got == 0) ? 1 : 40, $urandom_range(0, 3));
    end

    // Async reset in the middle of a divide
    start_run();
    drive_count(30, 1, 30, 0, got);
    halt = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    halt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.cycles", cycles, 32'd0);
    chk("arst.instrs", instrs, 32'd0);
    chk("arst.cpi", cpi, 40'd0);
    chk("arst.valid", cpi_valid, 1'b0);
    chk("arst.dz", div_zero, 1'b0);
    chk("arst.state", 64'(dbg_state), 64'(COUNT));
    #3 rst_n = 1'b1;
    tick();

    // Saturation on the narrow instance: 300 cycles, retire every cycle
    s_clear = 1'b1;
    tick();
    s_clear = 1'b0;
    s_retire = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    chk("sat.cycles", s_cycles, 8'hFF);
    chk("sat.instrs", s_instrs, 8'hFF);
    s_halt = 1'b1;
    tick();
    lat = 0;
    while (!s_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk("sat.latency", 64'(lat), 64'd16);
    chk("sat.cpi", s_cpi, 16'h0100);
    chk("sat.dz", s_dz, 1'b0);
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0;
    chk("sat.valid_drop", s_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
